// File: rtl/ebu_pkg.sv
// Shared EBU definitions: bus-owner FSM states and the burst-length helper.
package ebu_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} statetype;

  // Data beats minus one for an AHB burst. SINGLE and INCR are treated as one beat.
  function automatic logic [3:0] burst_threshold(input logic [2:0] hburst);
    logic [3:0] th;
    unique casez (hburst)
      3'b00?:  th = 4'd0;
      3'b01?:  th = 4'd3;
      3'b10?:  th = 4'd7;
      default: th = 4'd15;
    endcase
    return th;
  endfunction

endpackage

// File: rtl/ebu_rr_arbiter_rrpick.sv
// Rotating-priority picker: first set bit of Req scanning upward from Ptr, with wrap.
module rrpick #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] Req,
  input  logic [IW-1:0]   Ptr,
  output logic [NREQ-1:0] Pick,
  output logic [IW-1:0]   PickIdx
);

  logic found;
  int   j;

  // Walk the requesters starting at Ptr; the first one found wins.
  always_comb begin
    Pick    = '0;
    PickIdx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(Ptr) + k) % NREQ;
      if (!found && Req[j]) begin
        found   = 1'b1;
        Pick[j] = 1'b1;
        PickIdx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ebu_rr_arbiter.sv
// Round-robin owner arbiter for the shared EBU AHB manager port. Holds the
// grant for a whole burst by counting HREADY data beats.
module ebu_rr_arbiter
  import ebu_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [NREQ-1:0] Req,
  input  logic [2:0]      HBURST,
  input  logic            HREADY,
  output logic [NREQ-1:0] Grant,
  output logic [IW-1:0]   OwnerIdx,
  output logic            Busy,
  output logic [NREQ-1:0] Wait,
  output logic [NREQ-1:0] Save
);

  statetype        state;
  logic [IW-1:0]   ptr, owner, pick_idx, ptr_nxt;
  logic [3:0]      beatcnt, thresh;
  logic [NREQ-1:0] pick, waitd;

  rrpick #(.NREQ(NREQ)) u_pick (
    .Req     (Req),
    .Ptr     (ptr),
    .Pick    (pick),
    .PickIdx (pick_idx)
  );

  assign ptr_nxt  = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  assign Busy     = (state == BUSY);
  assign OwnerIdx = owner;
  assign Wait     = Req & ~Grant;
  assign Save     = Wait & ~waitd;

  // Idle: live pick gives zero-cycle grant. Busy: the latched owner keeps the bus.
  always_comb begin
    Grant = pick;
    if (state == BUSY) begin
      Grant        = '0;
      Grant[owner] = 1'b1;
    end
  end

  // Owner FSM: accept on an HREADY address phase, release after the final data beat.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      beatcnt <= '0;
      thresh  <= '0;
    end else begin
      case (state)
        IDLE: if (HREADY && |Req) begin
          state   <= BUSY;
          owner   <= pick_idx;
          thresh  <= burst_threshold(HBURST);
          beatcnt <= '0;
          ptr     <= ptr_nxt;
        end
        BUSY: if (HREADY) begin
          if (beatcnt == thresh) state <= IDLE;
          else                   beatcnt <= beatcnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delayed Wait so Save fires once on each new stall.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) waitd <= '0;
    else          waitd <= Wait;
  end

endmodule

// File: tb/tb_ebu_rr_arbiter.sv
// Self-checking bench for ebu_rr_arbiter (NREQ=3) against a transaction-level model.
module tb_ebu_rr_arbiter;
  localparam int N = 3;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [2:0] Req, HBURST;
  logic       HREADY;
  logic [2:0] Grant, Wait, Save;
  logic [1:0] OwnerIdx;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  // Model: current owner (-1 = none), data beats still owed, rotation start, last Wait.
  int         m_owner, m_left, m_ptr;
  logic [2:0] m_waitd;
  int         beats [4] = '{1, 4, 8, 16};

  always #5 HCLK = ~HCLK;

  ebu_rr_arbiter #(.NREQ(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .Req(Req), .HBURST(HBURST), .HREADY(HREADY),
    .Grant(Grant), .OwnerIdx(OwnerIdx), .Busy(Busy), .Wait(Wait), .Save(Save)
  );

  function automatic logic [2:0] m_pick();
    for (int k = 0; k < N; k++) begin
      automatic int jj = (m_ptr + k) % N;
      if (Req[jj]) return 3'(1 << jj);
    end
    return 3'b000;
  endfunction

  function automatic logic [2:0] m_grant();
    return (m_owner >= 0) ? 3'(1 << m_owner) : m_pick();
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [2:0] g, w;
    logic       b;
    g = m_grant();
    w = Req & ~g;
    b = (m_owner >= 0);
    return {g, w, w & ~m_waitd, b, b ? 2'(m_owner) : 2'b00};
  endfunction

  function automatic logic [11:0] act_vec();
    return {Grant, Wait, Save, Busy, Busy ? OwnerIdx : 2'b00};
  endfunction

  task automatic m_reset();
    m_owner = -1; m_left = 0; m_ptr = 0; m_waitd = 3'b000;
  endtask

  // Advance the model across one clock edge using the inputs held this cycle.
  task automatic m_tick();
    logic [2:0] g;
    g = m_grant();
    if (!HRESETn) begin m_reset(); return; end
    m_waitd = Req & ~g;
    if (m_owner < 0) begin
      if (HREADY && Req != 3'b000)
        for (int i = 0; i < N; i++)
          if (g[i]) begin m_owner = i; m_ptr = (i + 1) % N; m_left = beats[HBURST[2:1]]; end
    end else if (HREADY) begin
      m_left--;
      if (m_left == 0) m_owner = -1;
    end
  endtask

  task automatic cyc_in(input logic [2:0] r, input logic [2:0] b, input logic h);
    Req = r; HBURST = b; HREADY = h;
    @(negedge HCLK);
  endtask

  task automatic nxt();
    m_tick();
    @(posedge HCLK); #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; Req = 3'b000; HBURST = 3'b000; HREADY = 1'b1;
    m_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; m_reset();
    cyc_in(3'b000, 3'b000, 1'b1);
    if (Grant !== 3'b000 || Busy !== 1'b0 || OwnerIdx !== 2'd0 || Save !== 3'b000 || Wait !== 3'b000) begin
      errors++; $display("FAIL reset got grant=%b busy=%b own=%0d save=%b wait=%b exp 000/0/0/000/000",
                         Grant, Busy, OwnerIdx, Save, Wait);
    end
    checks++;
    HRESETn = 1'b1;
    nxt();
  endtask

  task automatic test_single();
    do_reset();
    cyc_in(3'b001, 3'b000, 1'b1);
    if (Grant !== 3'b001 || Busy !== 1'b0) begin
      errors++; $display("FAIL single_c0 got grant=%b busy=%b exp 001/0", Grant, Busy);
    end
    checks++;
    nxt();
    cyc_in(3'b000, 3'b000, 1'b1);
    if (Busy !== 1'b1 || Grant !== 3'b001 || OwnerIdx !== 2'd0) begin
      errors++; $display("FAIL single_c1 got busy=%b grant=%b own=%0d exp 1/001/0", Busy, Grant, OwnerIdx);
    end
    checks++;
    nxt();
    // Pointer has moved to 1, so requester 1 beats requester 0.
    cyc_in(3'b011, 3'b000, 1'b0);
    if (Busy !== 1'b0 || Grant !== 3'b010) begin
      errors++; $display("FAIL single_ptr got busy=%b grant=%b exp 0/010", Busy, Grant);
    end
    checks++;
    nxt();
  endtask

  task automatic test_incr4_pair();
    do_reset();
    cyc_in(3'b011, 3'b011, 1'b1);
    if (Grant !== 3'b001 || Save !== 3'b010 || Wait !== 3'b010) begin
      errors++; $display("FAIL incr4_c0 got grant=%b save=%b wait=%b exp 001/010/010", Grant, Save, Wait);
    end
    checks++;
    nxt();
    for (int c = 1; c <= 5; c++) begin
      cyc_in(3'b010, 3'b011, 1'b1);
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL incr4_c%0d got=%b exp=%b", c, act_vec(), exp_vec());
      end
      checks++;
      if (Grant !== ((c <= 4) ? 3'b001 : 3'b010) || Busy !== (c <= 4)) begin
        errors++; $display("FAIL incr4_grant_c%0d got grant=%b busy=%b", c, Grant, Busy);
      end
      checks++;
      if (c == 1 && Save !== 3'b000) begin
        errors++; $display("FAIL incr4_save_once got save=%b exp 000", Save);
      end
      checks++;
      nxt();
    end
  endtask

  task automatic test_rotation();
    logic [2:0] tbl [4];
    tbl = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc_in(3'b111, 3'b000, 1'b1);
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rot_c%0d got=%b exp=%b", c, act_vec(), exp_vec());
      end
      checks++;
      if (Grant !== tbl[c / 2] || Busy !== c[0]) begin
        errors++; $display("FAIL rot_seq_c%0d got grant=%b busy=%b exp %b/%b", c, Grant, Busy, tbl[c / 2], c[0]);
      end
      checks++;
      nxt();
    end
  endtask

  task automatic test_incr16_waits();
    do_reset();
    cyc_in(3'b001, 3'b111, 1'b1);
    nxt();
    for (int k = 0; k < 32; k++) begin
      cyc_in(3'b100, 3'b111, k[0]);
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL incr16_k%0d got=%b exp=%b", k, act_vec(), exp_vec());
      end
      checks++;
      if (Grant !== 3'b001 || Busy !== 1'b1) begin
        errors++; $display("FAIL incr16_hold_k%0d got grant=%b busy=%b exp 001/1", k, Grant, Busy);
      end
      checks++;
      nxt();
    end
    cyc_in(3'b100, 3'b000, 1'b0);
    if (Busy !== 1'b0 || Grant !== 3'b100) begin
      errors++; $display("FAIL incr16_end got busy=%b grant=%b exp 0/100", Busy, Grant);
    end
    checks++;
    nxt();
  endtask

  task automatic test_owner_drop();
    do_reset();
    cyc_in(3'b001, 3'b101, 1'b1);
    nxt();
    for (int k = 0; k < 8; k++) begin
      cyc_in(3'b100, 3'b101, 1'b1);
      if (Grant !== 3'b001 || Busy !== 1'b1 || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_k%0d got=%b exp=%b", k, act_vec(), exp_vec());
      end
      checks++;
      nxt();
    end
    cyc_in(3'b100, 3'b000, 1'b1);
    if (Grant !== 3'b100 || Busy !== 1'b0) begin
      errors++; $display("FAIL drop_next got grant=%b busy=%b exp 100/0", Grant, Busy);
    end
    checks++;
    nxt();
  endtask

  task automatic test_hready_low_idle();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc_in(3'b010, 3'b000, 1'b0);
      if (Grant !== 3'b010 || Busy !== 1'b0) begin
        errors++; $display("FAIL hrlow_k%0d got grant=%b busy=%b exp 010/0", k, Grant, Busy);
      end
      checks++;
      nxt();
    end
    cyc_in(3'b100, 3'b000, 1'b0);
    if (Grant !== 3'b100 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL hrlow_repick got=%b exp=%b", act_vec(), exp_vec());
    end
    checks++;
    Req = 3'b100; HREADY = 1'b1;
    nxt();
    cyc_in(3'b000, 3'b000, 1'b1);
    if (Busy !== 1'b1 || OwnerIdx !== 2'd2) begin
      errors++; $display("FAIL hrlow_accept got busy=%b own=%0d exp 1/2", Busy, OwnerIdx);
    end
    checks++;
    nxt();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    cyc_in(3'b001, 3'b101, 1'b1);
    nxt();
    for (int k = 0; k < 5; k++) begin
      cyc_in(3'b110, 3'b101, 1'b1);
      nxt();
    end
    HRESETn = 1'b0;
    m_reset();
    cyc_in(3'b110, 3'b000, 1'b1);
    if (Busy !== 1'b0 || Grant !== 3'b010 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL rstmid got busy=%b grant=%b exp 0/010", Busy, Grant);
    end
    checks++;
    HRESETn = 1'b1;
    nxt();
    cyc_in(3'b100, 3'b000, 1'b1);
    if (Busy !== 1'b1 || OwnerIdx !== 2'd1 || Grant !== 3'b010) begin
      errors++; $display("FAIL rstmid_fresh got busy=%b own=%0d grant=%b exp 1/1/010", Busy, OwnerIdx, Grant);
    end
    checks++;
    nxt();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cyc_in(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_c%0d req=%b got=%b exp=%b", c, Req, act_vec(), exp_vec());
      end
      checks++;
      nxt();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Req = 3'b000; HBURST = 3'b000; HREADY = 1'b1; HRESETn = 1'b0;
    test_reset();
    test_single();
    test_incr4_pair();
    test_rotation();
    test_incr16_waits();
    test_owner_drop();
    test_hready_low_idle();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
